// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline skid stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: default payload/control widths, the three-state occupancy enum
// and a helper that maps the state to an entry count.
package pipe_pkg;

    // Payload = ALU result (32) + RS2 data (32) + RD address (5).
    localparam int DATA_W_DEF = 69;
    // Control = {RegWrite, MemtoReg, MemRead, MemWrite}.
    localparam int CTRL_W_DEF = 4;

    // The encoding equals the number of held entries, which keeps occ_of trivial.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    function automatic logic [1:0] occ_of(input state_e s);
        logic [1:0] occ;
        case (s)
            ST_ONE:  occ = 2'd1;
            ST_FULL: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage slot (control + payload) with a load enable and a synchronous clear.
// Latency: 1 cycle from ld_i to the outputs.
// Backpressure: none; the owner decides when to load.
//
// Ports: clk_i, clr_i (sync clear, wins over load), ld_i, ctrl_i/data_i (next
// value), ctrl_o/data_o (held value).
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else if (ld_i) begin
            ctrl_q <= ctrl_i;
            data_q <= data_i;
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between pipeline stages (main/head slot + skid slot).
// Latency: 1 cycle from push to head; one entry per cycle sustained.
// Backpressure: in_ready_o is registered (state != FULL) and never sees out_ready_i combinationally.
//
// Ports: clk_i, rst_i (sync, active high), flush_i, in_valid_i/in_ready_o/
// in_ctrl_i/in_data_i (upstream), out_valid_o/out_ready_i/out_ctrl_o/
// out_data_o (downstream), occupancy_o (0..2 held entries).
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    state_e state_q, state_d;
    logic   in_ready_q;

    logic              push, pop;
    logic              main_ld, skid_ld, main_from_skid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
    logic [DATA_W-1:0] main_data, skid_data, main_data_d;

    assign push = in_valid_i & in_ready_q;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        // Flush only moves the state; the slots keep their contents so the
        // payload output still shows the last head while empty.
        if (!flush_i) begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        main_ld = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_ld = 1'b1;
                    end else if (push) begin
                        state_d = ST_FULL;
                        skid_ld = 1'b1;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready_q is low here, so only a pop can happen.
                    if (pop) begin
                        state_d        = ST_ONE;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end else begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            // Ready is a registered copy of "next state is not FULL".
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl_i;
    assign main_data_d = main_from_skid ? skid_data : in_data_i;

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk_i  (clk_i),
        .clr_i  (rst_i),
        .ld_i   (main_ld),
        .ctrl_i (main_ctrl_d),
        .data_i (main_data_d),
        .ctrl_o (main_ctrl),
        .data_o (main_data)
    );

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk_i  (clk_i),
        .clr_i  (rst_i),
        .ld_i   (skid_ld),
        .ctrl_i (in_ctrl_i),
        .data_i (in_data_i),
        .ctrl_o (skid_ctrl),
        .data_o (skid_data)
    );

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != ST_EMPTY);
    // A bubble must never carry RegWrite/MemWrite downstream.
    assign out_ctrl_o  = out_valid_o ? main_ctrl : '0;
    assign out_data_o  = main_data;
    assign occupancy_o = occ_of(state_q);

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table with hand-written expected
// outputs, plus a queue-based scoreboard that follows every cycle.
// Runs a directed table, a 16-entry stream and a random phase.
module tb_pipe_skid_stage;

    localparam int DW = 69;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_i, flush_i, in_valid_i, out_ready_i;
    logic          in_ready_o, out_valid_o;
    logic [CW-1:0] in_ctrl_i, out_ctrl_o;
    logic [DW-1:0] in_data_i, out_data_o;
    logic [1:0]    occupancy_o;

    always #5 clk = ~clk;

    pipe_skid_stage dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_ctrl_i   (in_ctrl_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_ctrl_o  (out_ctrl_o),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o)
    );

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    typedef struct {
        logic          rst, flush, vld, ordy;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        logic          e_vld, e_rdy;
        logic [1:0]    e_occ;
        logic [CW-1:0] e_ctrl;
        logic [DW-1:0] e_data;
    } vec_t;

    int            n_chk = 0;
    int            n_err = 0;
    entry_t        sb[$];
    logic [DW-1:0] last_head;
    bit            sb_on = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle: compare current outputs to the scoreboard, advance the
    // reference queue with this cycle's inputs, then let the edge happen.
    task automatic cycle(input logic r, input logic f, input logic v,
                         input logic [CW-1:0] c, input logic [DW-1:0] d, input logic o);
        bit do_pop, do_push;
        entry_t e;
        rst_i = r; flush_i = f; in_valid_i = v; in_ctrl_i = c; in_data_i = d; out_ready_i = o;
        if (sb_on) begin
            chk("sb_valid", out_valid_o, sb.size() > 0);
            chk("sb_ready", in_ready_o, sb.size() < 2);
            chk("sb_occ", occupancy_o, sb.size());
            if (sb.size() > 0) begin
                chk("sb_head_ctrl", out_ctrl_o, sb[0].ctrl);
                chk("sb_head_data", out_data_o, sb[0].data);
            end else begin
                chk("sb_bubble_ctrl", out_ctrl_o, 0);
                chk("sb_bubble_data", out_data_o, last_head);
            end
        end
        if (r) begin
            sb.delete();
            last_head = '0;
            sb_on = 1;
        end else if (f) begin
            sb.delete();
        end else begin
            do_pop  = (sb.size() > 0) && o;
            do_push = v && (sb.size() < 2);
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                e.ctrl = c; e.data = d;
                sb.push_back(e);
            end
        end
        if (sb.size() > 0) last_head = sb[0].data;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic v,
                                input logic [CW-1:0] c, input logic [DW-1:0] d, input logic o,
                                input logic ev, input logic er, input logic [1:0] eo,
                                input logic [CW-1:0] ec, input logic [DW-1:0] ed);
        vec_t t;
        t.rst = r; t.flush = f; t.vld = v; t.ctrl = c; t.data = d; t.ordy = o;
        t.e_vld = ev; t.e_rdy = er; t.e_occ = eo; t.e_ctrl = ec; t.e_data = ed;
        return t;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        vec_t          tbl[17];
        logic [DW-1:0] A, B, C, D, E, F, G, H;
        logic [DW-1:0] rd;
        A = 69'h1F_DEADBEEF_CAFEF00D;
        B = 69'h0B_0000000B_0000000B;
        C = 69'h0C_0000000C_0000000C;
        D = 69'h00_00000000_0000000D;
        E = 69'h15_12345678_9ABCDEF0;
        F = 69'h0F_FFFFFFFF_FFFFFFFF;
        G = 69'h07_00000007_00000007;
        H = 69'h08_00000008_00000008;

        //            rst flush vld ctrl     data     ordy | vld rdy occ ctrl     data
        tbl[0]  = mk(1, 0, 0, 4'b0000, '0,      0,   0, 1, 2'd0, 4'b0000, '0);
        tbl[1]  = mk(1, 0, 0, 4'b0000, '0,      0,   0, 1, 2'd0, 4'b0000, '0);
        // first push, visible after one edge
        tbl[2]  = mk(0, 0, 1, 4'b1000, 69'h1,   1,   1, 1, 2'd1, 4'b1000, 69'h1);
        tbl[3]  = mk(0, 0, 0, 4'b0000, '0,      1,   0, 1, 2'd0, 4'b0000, 69'h1);
        // A, B, C under stall: C refused, head stays A
        tbl[4]  = mk(0, 0, 1, 4'b0001, A,       0,   1, 1, 2'd1, 4'b0001, A);
        tbl[5]  = mk(0, 0, 1, 4'b0010, B,       0,   1, 0, 2'd2, 4'b0001, A);
        tbl[6]  = mk(0, 0, 1, 4'b0100, C,       0,   1, 0, 2'd2, 4'b0001, A);
        tbl[7]  = mk(0, 0, 0, 4'b0000, '0,      0,   1, 0, 2'd2, 4'b0001, A);
        // drain FULL: B becomes head, then empty with zero ctrl
        tbl[8]  = mk(0, 0, 0, 4'b0000, '0,      1,   1, 1, 2'd1, 4'b0010, B);
        tbl[9]  = mk(0, 0, 0, 4'b0000, '0,      1,   0, 1, 2'd0, 4'b0000, B);
        // flush in FULL with a push
        tbl[10] = mk(0, 0, 1, 4'b1000, D,       0,   1, 1, 2'd1, 4'b1000, D);
        tbl[11] = mk(0, 0, 1, 4'b0011, E,       0,   1, 0, 2'd2, 4'b1000, D);
        tbl[12] = mk(0, 1, 1, 4'b1111, F,       1,   0, 1, 2'd0, 4'b0000, D);
        tbl[13] = mk(0, 0, 0, 4'b0000, '0,      1,   0, 1, 2'd0, 4'b0000, D);
        // reset beats flush and push in ONE
        tbl[14] = mk(0, 0, 1, 4'b1001, G,       0,   1, 1, 2'd1, 4'b1001, G);
        tbl[15] = mk(1, 1, 1, 4'b1111, H,       1,   0, 1, 2'd0, 4'b0000, '0);
        tbl[16] = mk(0, 0, 0, 4'b0000, '0,      0,   0, 1, 2'd0, 4'b0000, '0);

        rst_i = 1; flush_i = 0; in_valid_i = 0; in_ctrl_i = '0; in_data_i = '0; out_ready_i = 0;

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].rst, tbl[i].flush, tbl[i].vld, tbl[i].ctrl, tbl[i].data, tbl[i].ordy);
            chk($sformatf("vec%0d_valid", i), out_valid_o, tbl[i].e_vld);
            chk($sformatf("vec%0d_ready", i), in_ready_o, tbl[i].e_rdy);
            chk($sformatf("vec%0d_occ", i), occupancy_o, tbl[i].e_occ);
            chk($sformatf("vec%0d_ctrl", i), out_ctrl_o, tbl[i].e_ctrl);
            chk($sformatf("vec%0d_data", i), out_data_o, tbl[i].e_data);
        end

        // Stream 0..15 with the sink always ready: one output per cycle, in order.
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 1, 4'(i), DW'(i), 1);
            chk($sformatf("stream%0d_data", i), out_data_o, DW'(i));
            chk($sformatf("stream%0d_occ_le1", i), occupancy_o <= 2'd1, 1'b1);
        end
        cycle(0, 0, 0, '0, '0, 1);
        chk("stream_drained_occ", occupancy_o, 2'd0);

        // Random traffic with occasional flushes; the scoreboard checks order.
        for (int i = 0; i < 300; i++) begin
            rd = {5'($urandom), $urandom(), $urandom()};
            cycle(0, ($urandom_range(0, 15) == 0), 1'($urandom), 4'($urandom), rd, 1'($urandom));
        end
        // Final drain so the last state is compared too.
        cycle(0, 0, 0, '0, '0, 1);
        cycle(0, 0, 0, '0, '0, 1);
        cycle(0, 0, 0, '0, '0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
